bht_port_ctrl: RTL and testbench



---
 rtl/bht_pkg.sv | 28 ++
 rtl/bht_port_ctrl_if.sv | 33 +++
 rtl/bht_upd_fifo.sv | 62 ++++++
 rtl/bht_port_ctrl.sv | 150 +++++++++++++++
 tb/tb_bht_port_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table port controller:
// FSM state encoding, 2-bit counter encodings and the saturating update rule.
package bht_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UPD_WR = 2'd2
  } bht_state_e;

  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;
  localparam logic [1:0] BHT_INIT_VAL  = CNT_WEAK_NT;

  function automatic logic [1:0] bht_sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_STRONG_T) res = cnt + 2'd1;
    end else begin
      if (cnt != CNT_STRONG_NT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bht_port_ctrl_if.sv
// Bundle of lookup, update and SRAM-port signals for bht_port_ctrl.
// slave = controller side, master = fetch/execute/SRAM environment side.
interface bht_port_ctrl_if #(
  parameter int IDX_W = 6
);
  logic             ilookup_valid;
  logic [IDX_W-1:0] ilookup_idx;
  logic             olookup_ready;
  logic             olookup_rvalid;
  logic             olookup_taken;
  logic             iupd_valid;
  logic [IDX_W-1:0] iupd_idx;
  logic             iupd_taken;
  logic             oupd_ready;
  logic             omem_en;
  logic             omem_we;
  logic [IDX_W-1:0] omem_addr;
  logic [1:0]       omem_wdata;
  logic [1:0]       imem_rdata;
  logic             oinit_done;

  modport slave (
    input  ilookup_valid, ilookup_idx, iupd_valid, iupd_idx, iupd_taken, imem_rdata,
    output olookup_ready, olookup_rvalid, olookup_taken, oupd_ready,
           omem_en, omem_we, omem_addr, omem_wdata, oinit_done
  );

  modport master (
    output ilookup_valid, ilookup_idx, iupd_valid, iupd_idx, iupd_taken, imem_rdata,
    input  olookup_ready, olookup_rvalid, olookup_taken, oupd_ready,
           omem_en, omem_we, omem_addr, omem_wdata, oinit_done
  );
endinterface

// File: rtl/bht_upd_fifo.sv
// Small synchronous FIFO of pending {idx, taken} updates; pointers carry an
// extra wrap bit so full/empty are distinguished without a counter.
module bht_upd_fifo #(
  parameter int IDX_W      = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_taken,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [IDX_W-1:0] head_idx,
  output logic             head_taken
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = IDX_W + 1;

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0] ent_arr [FIFO_DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [ENT_W-1:0] entry_q, entry_d;
      always_comb begin
        entry_d = entry_q;
        if (push && (wr_ptr_q[PTR_W-1:0] == PTR_W'(gi))) entry_d = {push_idx, push_taken};
      end
      always_ff @(posedge clk) begin
        entry_q <= entry_d;
      end
      assign ent_arr[gi] = entry_q;
    end
  endgenerate

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign {head_idx, head_taken} = ent_arr[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/bht_port_ctrl.sv
// Single-port BHT controller: table init after reset, lookup/update arbitration,
// read-modify-write of 2-bit counters. BHT_STATS_EN builds the statistics counters.
module bht_port_ctrl
  import bht_pkg::*;
#(
  parameter int IDX_W      = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  bht_port_ctrl_if.slave bus,
  output logic [31:0] olookup_cnt,
  output logic [31:0] ostall_cnt
);
  localparam logic [IDX_W-1:0] LAST_ADDR = '1;

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] init_addr_q, init_addr_d;
  logic             init_done_q, init_done_d;
  logic             rvalid_q, rvalid_d;

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic             lookup_ready, lookup_fire, upd_ready;
  logic             mem_en, mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [1:0]       mem_wdata;

  bht_upd_fifo #(.IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_idx   (bus.iupd_idx),
    .push_taken (bus.iupd_taken),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_idx   (head_idx),
    .head_taken (head_taken)
  );

  // Handshakes are masked during reset so nothing is accepted in a cycle that is being discarded.
  assign lookup_ready = (state_q == ST_RUN) && !fifo_full && !rst;
  assign lookup_fire  = bus.ilookup_valid && lookup_ready;
  assign upd_ready    = (state_q != ST_INIT) && !fifo_full && !rst;
  assign fifo_push    = bus.iupd_valid && upd_ready;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        mem_en      = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = init_addr_q;
        mem_wdata   = BHT_INIT_VAL;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_ADDR) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        // A full FIFO must drain first, otherwise lookups could starve updates forever.
        if (fifo_full) begin
          mem_en   = 1'b1;
          mem_addr = head_idx;
          state_d  = ST_UPD_WR;
        end else if (bus.ilookup_valid) begin
          mem_en   = 1'b1;
          mem_addr = bus.ilookup_idx;
        end else if (!fifo_empty) begin
          mem_en   = 1'b1;
          mem_addr = head_idx;
          state_d  = ST_UPD_WR;
        end
      end
      ST_UPD_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_idx;
        mem_wdata = bht_sat_update(bus.imem_rdata, head_taken);
        fifo_pop  = 1'b1;
        state_d   = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
    rvalid_d = lookup_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign bus.olookup_ready  = lookup_ready;
  assign bus.olookup_rvalid = rvalid_q && !rst;
  assign bus.olookup_taken  = rvalid_q && !rst && bus.imem_rdata[1];
  assign bus.oupd_ready     = upd_ready;
  assign bus.omem_en        = mem_en && !rst;
  assign bus.omem_we        = mem_we && !rst;
  assign bus.omem_addr      = mem_addr;
  assign bus.omem_wdata     = mem_wdata;
  assign bus.oinit_done     = init_done_q && !rst;

`ifdef BHT_STATS_EN
  logic [31:0] lookup_cnt_q, lookup_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    lookup_cnt_d = lookup_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (lookup_fire) lookup_cnt_d = lookup_cnt_q + 32'd1;
    if ((state_q == ST_RUN) && bus.ilookup_valid && !lookup_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      lookup_cnt_q <= lookup_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign olookup_cnt = lookup_cnt_q;
  assign ostall_cnt  = stall_cnt_q;
`else
  assign olookup_cnt = 32'd0;
  assign ostall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_bht_port_ctrl.sv
// Self-checking bench for bht_port_ctrl (IDX_W=3, FIFO_DEPTH=2): table-driven
// lookup/update vectors, lookup scoreboard, and hand-written reset/full-FIFO sequences.
module tb_bht_port_ctrl;
  localparam int IDX_W = 3;
  localparam int DEPTH = 1 << IDX_W;
  localparam int NVEC  = 13;

  typedef struct packed {
    logic             is_upd;
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic             exp_taken;
    logic [1:0]       exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_cnt, stall_cnt;

  bht_port_ctrl_if #(.IDX_W(IDX_W)) bus ();

  bht_port_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .olookup_cnt (lookup_cnt),
    .ostall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  logic [1:0] sram [DEPTH];
  logic [1:0] ref_tbl [DEPTH];
  logic       sb_q [$];
  logic       lk_exp;
  vec_t       tbl [NVEC];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_acc    = 0;
  int         n_stall  = 0;

  // Behavioural SRAM with one-cycle registered read.
  always @(posedge clk) begin
    if (bus.omem_en) begin
      if (bus.omem_we) sram[bus.omem_addr] <= bus.omem_wdata;
      else             bus.imem_rdata <= sram[bus.omem_addr];
    end
  end

  function automatic logic [1:0] tb_next(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s = %0h @%0t", name, act, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake never completed @%0t", name, $time);
  endtask

  // Scoreboard monitor: pushes an expected prediction on acceptance, pops on rvalid.
  initial begin
    logic prev_acc;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        n_acc    = 0;
        n_stall  = 0;
        prev_acc = 1'b0;
      end else begin
        if (bus.olookup_rvalid || prev_acc) check("rvalid_latency", bus.olookup_rvalid, prev_acc);
        if (bus.olookup_rvalid && sb_q.size() > 0) check("lookup_taken", bus.olookup_taken, sb_q.pop_front());
        prev_acc = bus.ilookup_valid & bus.olookup_ready;
        if (prev_acc) begin
          sb_q.push_back(lk_exp);
          n_acc++;
        end
        if (bus.ilookup_valid && !bus.olookup_ready && bus.oinit_done && !(bus.omem_en && bus.omem_we))
          n_stall++;
      end
    end
  end

  task automatic do_update(input logic [IDX_W-1:0] idx, input logic tk);
    int guard;
    guard = 0;
    bus.iupd_valid = 1'b1;
    bus.iupd_idx   = idx;
    bus.iupd_taken = tk;
    @(negedge clk);
    while (!bus.oupd_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) timeout("upd_accept");
    else ref_tbl[idx] = tb_next(ref_tbl[idx], tk);
    @(posedge clk); #1;
    bus.iupd_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [IDX_W-1:0] idx, input logic exp);
    int guard;
    guard = 0;
    bus.ilookup_valid = 1'b1;
    bus.ilookup_idx   = idx;
    lk_exp            = exp;
    @(negedge clk);
    while (!bus.olookup_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) timeout("lookup_accept");
    @(posedge clk); #1;
    bus.ilookup_valid = 1'b0;
  endtask

  // Called right after rst drops: expects one 01 write per address, then oinit_done.
  task automatic check_init();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      check("init_write", {bus.omem_en, bus.omem_we}, 2'b11);
      check("init_addr", bus.omem_addr, a);
      check("init_wdata", bus.omem_wdata, 2'b01);
      check("init_done_low", bus.oinit_done, 1'b0);
      if (a == 0) check("init_upd_ready", bus.oupd_ready, 1'b0);
    end
    @(negedge clk);
    check("init_done_rise", bus.oinit_done, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 3'd5, 1'b0, 1'b0, 2'b00};
    tbl[1]  = '{1'b1, 3'd2, 1'b1, 1'b0, 2'b10};
    tbl[2]  = '{1'b1, 3'd2, 1'b1, 1'b0, 2'b11};
    tbl[3]  = '{1'b1, 3'd2, 1'b1, 1'b0, 2'b11};
    tbl[4]  = '{1'b0, 3'd2, 1'b0, 1'b1, 2'b00};
    tbl[5]  = '{1'b1, 3'd2, 1'b0, 1'b0, 2'b10};
    tbl[6]  = '{1'b1, 3'd2, 1'b0, 1'b0, 2'b01};
    tbl[7]  = '{1'b0, 3'd2, 1'b0, 1'b0, 2'b00};
    tbl[8]  = '{1'b1, 3'd6, 1'b0, 1'b0, 2'b00};
    tbl[9]  = '{1'b1, 3'd6, 1'b0, 1'b0, 2'b00};
    tbl[10] = '{1'b0, 3'd6, 1'b0, 1'b0, 2'b00};
    tbl[11] = '{1'b1, 3'd6, 1'b1, 1'b0, 2'b01};
    tbl[12] = '{1'b0, 3'd6, 1'b0, 1'b0, 2'b00};

    bus.ilookup_valid = 1'b0;
    bus.ilookup_idx   = '0;
    bus.iupd_valid    = 1'b0;
    bus.iupd_idx      = '0;
    bus.iupd_taken    = 1'b0;
    lk_exp            = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 2'b01;

    // Reset state and initialisation
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_done", bus.oinit_done, 1'b0);
    check("rst_rvalid", bus.olookup_rvalid, 1'b0);
    check("rst_mem_en", bus.omem_en, 1'b0);
    check("rst_upd_ready", bus.oupd_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_init();

    // Table-driven lookups and updates, each update drained before the next row
    for (int r = 0; r < NVEC; r++) begin
      if (tbl[r].is_upd) begin
        do_update(tbl[r].idx, tbl[r].taken);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check($sformatf("vec%0d_cnt", r), sram[tbl[r].idx], tbl[r].exp_cnt);
        @(posedge clk); #1;
      end else begin
        do_lookup(tbl[r].idx, tbl[r].exp_taken);
        repeat (2) @(posedge clk); #1;
      end
    end

    // Reset while in UPD_WR: write suppressed, FIFO flushed, INIT restarts at 0
    do_update(3'd3, 1'b1);
    @(negedge clk);
    check("pri3_read", {bus.omem_en, bus.omem_we}, 2'b10);
    check("pri3_addr", bus.omem_addr, 3'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 2'b01;
    @(negedge clk);
    check("rst_updwr_mem_en", bus.omem_en, 1'b0);
    check("rst_updwr_rvalid", bus.olookup_rvalid, 1'b0);
    check("rst_updwr_done", bus.oinit_done, 1'b0);
    check("rst_updwr_lk_ready", bus.olookup_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_init();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_after_rst", bus.omem_en, 1'b0);
    end
    check("rst_dropped_upd", sram[3], 2'b01);
    @(posedge clk); #1;

    // Reset discards an in-flight lookup result
    bus.ilookup_idx   = 3'd0;
    bus.ilookup_valid = 1'b1;
    lk_exp            = 1'b0;
    @(negedge clk);
    check("inflight_accept", bus.olookup_ready, 1'b1);
    @(posedge clk); #1;
    bus.ilookup_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("inflight_rvalid", bus.olookup_rvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_init();

    // FIFO fills behind continuous lookups; the update read must then win the port
    bus.ilookup_idx   = 3'd7;
    bus.ilookup_valid = 1'b1;
    lk_exp            = ref_tbl[7][1];
    bus.iupd_valid    = 1'b1;
    bus.iupd_idx      = 3'd0;
    bus.iupd_taken    = 1'b1;
    @(negedge clk);
    check("full_s1_upd_ready", bus.oupd_ready, 1'b1);
    check("full_s1_lk_ready", bus.olookup_ready, 1'b1);
    ref_tbl[0] = tb_next(ref_tbl[0], 1'b1);
    @(posedge clk); #1;
    bus.iupd_idx = 3'd1;
    @(negedge clk);
    check("full_s2_upd_ready", bus.oupd_ready, 1'b1);
    ref_tbl[1] = tb_next(ref_tbl[1], 1'b1);
    @(posedge clk); #1;
    bus.iupd_valid = 1'b0;
    @(negedge clk);
    check("full_s3_upd_ready", bus.oupd_ready, 1'b0);
    check("full_s3_lk_ready", bus.olookup_ready, 1'b0);
    check("full_s3_read", {bus.omem_en, bus.omem_we}, 2'b10);
    check("full_s3_addr", bus.omem_addr, 3'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_s4_write", {bus.omem_en, bus.omem_we}, 2'b11);
    check("full_s4_wdata", bus.omem_wdata, ref_tbl[0]);
    check("full_s4_lk_ready", bus.olookup_ready, 1'b0);
    check("full_s4_upd_ready", bus.oupd_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_s5_upd_ready", bus.oupd_ready, 1'b1);
    check("full_s5_lk_ready", bus.olookup_ready, 1'b1);
    @(posedge clk); #1;
    bus.ilookup_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("full_cnt0", sram[0], ref_tbl[0]);
    check("full_cnt1", sram[1], ref_tbl[1]);
    @(posedge clk); #1;

    // Random updates interleaved with random lookups to an untouched index
    fork
      begin
        bus.ilookup_idx = 3'd7;
        lk_exp          = ref_tbl[7][1];
        for (int i = 0; i < 80; i++) begin
          bus.ilookup_valid = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        bus.ilookup_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 24; i++) do_update(3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    join
    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) check($sformatf("final_cnt%0d", i), sram[i], ref_tbl[i]);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      do_lookup(3'(i), ref_tbl[i][1]);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

`ifdef BHT_STATS_EN
    check("stat_lookup_cnt", lookup_cnt, n_acc);
    check("stat_stall_cnt", stall_cnt, n_stall);
`else
    check("stat_lookup_cnt_off", lookup_cnt, 32'd0);
    check("stat_stall_cnt_off", stall_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
